// File: rtl/mouse_pkg.sv
// Shared types and constants for the mouse cursor / selection block.
package mouse_pkg;

  // Coordinate width used for cursor and captured points.
  localparam int COORD_W = 10;

  // Bit positions inside the {mid, right, left} button vector.
  localparam int BTN_L = 0;
  localparam int BTN_R = 1;
  localparam int BTN_M = 2;

  // Two-click selection FSM states; encoding is visible on sel_state.
  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    HAVE_START = 2'd1,
    PRESENT    = 2'd2
  } sel_state_t;

endpackage

// File: rtl/cursor_axis.sv
// One cursor axis: picks the packet delta (optionally inverted, zeroed on
// overflow), optionally accelerates it, adds it to the current position and
// clamps the result to [0, MAX]. Purely combinational.
// Optional feature: define MOUSE_ACCEL_EN to double deltas whose magnitude
// exceeds ACCEL_THRESH.
module cursor_axis
  import mouse_pkg::*;
#(
  parameter int MAX          = 639,
  parameter int ACCEL_THRESH = 8
) (
  input  logic [COORD_W-1:0] pos_i,
  input  logic [8:0]         delta_i,
  input  logic               invert_i,
  input  logic               ovf_i,
  output logic [COORD_W-1:0] next_o
);

`ifdef MOUSE_ACCEL_EN
  localparam bit ACCEL_ON = 1'b1;
`else
  localparam bit ACCEL_ON = 1'b0;
`endif

  // 12 bits leaves headroom for a doubled delta on top of the largest position.
  localparam logic signed [11:0] MAX_S = 12'(MAX);
  localparam logic signed [11:0] THR_S = 12'(ACCEL_THRESH);

  logic signed [11:0] delta_s;
  logic signed [11:0] step_s;
  logic signed [11:0] sum_s;

  // Delta select, optional acceleration, add and clamp.
  always_comb begin
    delta_s = {{3{delta_i[8]}}, delta_i};
    if (invert_i) begin
      delta_s = -delta_s;
    end
    if (ovf_i) begin
      delta_s = '0;
    end
    step_s = delta_s;
    if (ACCEL_ON && ((delta_s > THR_S) || (delta_s < -THR_S))) begin
      step_s = delta_s <<< 1;
    end
    sum_s = $signed({2'b00, pos_i}) + step_s;
    if (sum_s < 12'sd0) begin
      next_o = '0;
    end else if (sum_s > MAX_S) begin
      next_o = MAX_S[COORD_W-1:0];
    end else begin
      next_o = sum_s[COORD_W-1:0];
    end
  end

endmodule

// File: rtl/mouse_cursor_select.sv
// Cursor accumulator plus two-click start/end selection for the path search.
// Motion and button edges are taken from decoded PS/2 packets; the FSM hands
// the captured pair to the consumer over a valid/ready handshake.
// Optional feature: MOUSE_ACCEL_EN enables delta doubling inside cursor_axis.
module mouse_cursor_select
  import mouse_pkg::*;
#(
  parameter int H_MAX        = 639,
  parameter int V_MAX        = 479,
  parameter int X_INIT       = 320,
  parameter int Y_INIT       = 240,
  parameter int ACCEL_THRESH = 8
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic               pkt_valid,
  input  logic [2:0]         pkt_btn,
  input  logic [8:0]         pkt_dx,
  input  logic [8:0]         pkt_dy,
  input  logic               pkt_xov,
  input  logic               pkt_yov,
  output logic [COORD_W-1:0] cursor_x,
  output logic [COORD_W-1:0] cursor_y,
  output logic [2:0]         btn_held,
  output logic               sel_valid,
  input  logic               sel_ready,
  output logic [COORD_W-1:0] sel_start_x,
  output logic [COORD_W-1:0] sel_start_y,
  output logic [COORD_W-1:0] sel_end_x,
  output logic [COORD_W-1:0] sel_end_y,
  output logic [1:0]         sel_state,
  output logic [7:0]         drop_cnt
);

  logic [COORD_W-1:0] cur_x_q, cur_y_q;
  logic [COORD_W-1:0] next_x, next_y;
  logic [2:0]         btn_held_q;
  logic [2:0]         press;
  sel_state_t         state_q, state_d;
  logic               sel_valid_q;
  logic [COORD_W-1:0] start_x_q, start_x_d, start_y_q, start_y_d;
  logic [COORD_W-1:0] end_x_q, end_x_d, end_y_q, end_y_d;
  logic [7:0]         drop_q, drop_d;

  // Screen Y grows downward, so the Y axis inverts the PS/2 delta.
  cursor_axis #(.MAX(H_MAX), .ACCEL_THRESH(ACCEL_THRESH)) u_axis_x (
    .pos_i    (cur_x_q),
    .delta_i  (pkt_dx),
    .invert_i (1'b0),
    .ovf_i    (pkt_xov),
    .next_o   (next_x)
  );

  cursor_axis #(.MAX(V_MAX), .ACCEL_THRESH(ACCEL_THRESH)) u_axis_y (
    .pos_i    (cur_y_q),
    .delta_i  (pkt_dy),
    .invert_i (1'b1),
    .ovf_i    (pkt_yov),
    .next_o   (next_y)
  );

  assign press = pkt_valid ? (pkt_btn & ~btn_held_q) : 3'b000;

  // Selection FSM next state, captures and drop counter.
  always_comb begin
    state_d   = state_q;
    start_x_d = start_x_q;
    start_y_d = start_y_q;
    end_x_d   = end_x_q;
    end_y_d   = end_y_q;
    drop_d    = drop_q;
    case (state_q)
      IDLE: begin
        if (press[BTN_L]) begin
          start_x_d = next_x;
          start_y_d = next_y;
          state_d   = HAVE_START;
        end
      end
      HAVE_START: begin
        // Right press cancels, even when left is pressed in the same packet.
        if (press[BTN_R]) begin
          state_d = IDLE;
        end else if (press[BTN_L]) begin
          end_x_d = next_x;
          end_y_d = next_y;
          state_d = PRESENT;
        end
      end
      PRESENT: begin
        if (press[BTN_L] && (drop_q != 8'hFF)) begin
          drop_d = drop_q + 8'd1;
        end
        if (sel_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, cursor and capture registers.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      cur_x_q     <= COORD_W'(X_INIT);
      cur_y_q     <= COORD_W'(Y_INIT);
      btn_held_q  <= '0;
      state_q     <= IDLE;
      sel_valid_q <= 1'b0;
      start_x_q   <= '0;
      start_y_q   <= '0;
      end_x_q     <= '0;
      end_y_q     <= '0;
      drop_q      <= '0;
    end else begin
      if (pkt_valid) begin
        cur_x_q    <= next_x;
        cur_y_q    <= next_y;
        btn_held_q <= pkt_btn;
      end
      state_q     <= state_d;
      sel_valid_q <= (state_d == PRESENT);
      start_x_q   <= start_x_d;
      start_y_q   <= start_y_d;
      end_x_q     <= end_x_d;
      end_y_q     <= end_y_d;
      drop_q      <= drop_d;
    end
  end

  assign cursor_x    = cur_x_q;
  assign cursor_y    = cur_y_q;
  assign btn_held    = btn_held_q;
  assign sel_valid   = sel_valid_q;
  assign sel_start_x = start_x_q;
  assign sel_start_y = start_y_q;
  assign sel_end_x   = end_x_q;
  assign sel_end_y   = end_y_q;
  assign sel_state   = state_q;
  assign drop_cnt    = drop_q;

endmodule

// File: tb/tb_mouse_cursor_select.sv
// Testbench for mouse_cursor_select: directed scenarios plus random packets,
// checked every cycle against an integer reference model.
module tb_mouse_cursor_select;

`ifdef MOUSE_ACCEL_EN
  localparam int ACC = 2;
`else
  localparam int ACC = 1;
`endif

  logic       Clk = 1'b0;
  logic       Reset = 1'b0;
  logic       pkt_valid = 1'b0;
  logic [2:0] pkt_btn = '0;
  logic [8:0] pkt_dx = '0;
  logic [8:0] pkt_dy = '0;
  logic       pkt_xov = 1'b0;
  logic       pkt_yov = 1'b0;
  logic       sel_ready = 1'b0;
  logic [9:0] cursor_x, cursor_y, sel_start_x, sel_start_y, sel_end_x, sel_end_y;
  logic [2:0] btn_held;
  logic       sel_valid;
  logic [1:0] sel_state;
  logic [7:0] drop_cnt;

  mouse_cursor_select dut (
    .Clk(Clk), .Reset(Reset), .pkt_valid(pkt_valid), .pkt_btn(pkt_btn),
    .pkt_dx(pkt_dx), .pkt_dy(pkt_dy), .pkt_xov(pkt_xov), .pkt_yov(pkt_yov),
    .cursor_x(cursor_x), .cursor_y(cursor_y), .btn_held(btn_held),
    .sel_valid(sel_valid), .sel_ready(sel_ready),
    .sel_start_x(sel_start_x), .sel_start_y(sel_start_y),
    .sel_end_x(sel_end_x), .sel_end_y(sel_end_y),
    .sel_state(sel_state), .drop_cnt(drop_cnt)
  );

  always #5 Clk = ~Clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  int m_x, m_y, m_held, m_st, m_sv, m_sx, m_sy, m_ex, m_ey, m_drop;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int clampi(input int v, input int mx);
    if (v < 0) return 0;
    if (v > mx) return mx;
    return v;
  endfunction

  function automatic int accel(input int d);
    if (ACC == 2 && (d > 8 || d < -8)) return 2 * d;
    return d;
  endfunction

  task automatic check_all();
    check_eq("cursor_x", int'(cursor_x), m_x);
    check_eq("cursor_y", int'(cursor_y), m_y);
    check_eq("btn_held", int'(btn_held), m_held);
    check_eq("sel_state", int'(sel_state), m_st);
    check_eq("sel_valid", int'(sel_valid), m_sv);
    check_eq("sel_start_x", int'(sel_start_x), m_sx);
    check_eq("sel_start_y", int'(sel_start_y), m_sy);
    check_eq("sel_end_x", int'(sel_end_x), m_ex);
    check_eq("sel_end_y", int'(sel_end_y), m_ey);
    check_eq("drop_cnt", int'(drop_cnt), m_drop);
  endtask

  // One clock cycle: drive inputs, advance the model, check after the edge.
  task automatic do_cycle(input bit rst, input bit valid, input int btn,
                          input int dx, input int dy, input bit xov,
                          input bit yov, input bit ready);
    int nx, ny, press;
    Reset     = rst;
    pkt_valid = valid;
    pkt_btn   = 3'(btn);
    pkt_dx    = 9'(dx);
    pkt_dy    = 9'(dy);
    pkt_xov   = xov;
    pkt_yov   = yov;
    sel_ready = ready;
    nx = clampi(m_x + (xov ? 0 : accel(dx)), 639);
    ny = clampi(m_y + (yov ? 0 : accel(-dy)), 479);
    press = valid ? (btn & ~m_held & 7) : 0;
    if (rst) begin
      m_x = 320; m_y = 240; m_held = 0; m_st = 0;
      m_sx = 0; m_sy = 0; m_ex = 0; m_ey = 0; m_drop = 0;
    end else begin
      if (valid) begin
        m_x = nx; m_y = ny; m_held = btn & 7;
      end
      if (m_st == 0) begin
        if (press[0]) begin m_sx = nx; m_sy = ny; m_st = 1; end
      end else if (m_st == 1) begin
        if (press[1]) m_st = 0;
        else if (press[0]) begin m_ex = nx; m_ey = ny; m_st = 2; end
      end else begin
        if (press[0] && m_drop < 255) m_drop++;
        if (ready) m_st = 0;
      end
    end
    m_sv = (m_st == 2) ? 1 : 0;
    @(posedge Clk);
    #1;
    check_all();
  endtask

  task automatic pkt(input int btn, input int dx, input int dy);
    do_cycle(1'b0, 1'b1, btn, dx, dy, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic idle(input bit ready);
    do_cycle(1'b0, 1'b0, 0, 0, 0, 1'b0, 1'b0, ready);
  endtask

  initial begin
    m_x = 0; m_y = 0; m_held = 0; m_st = 0; m_sv = 0;
    m_sx = 0; m_sy = 0; m_ex = 0; m_ey = 0; m_drop = 0;
    @(negedge Clk);
    do_cycle(1'b1, 1'b0, 0, 0, 0, 1'b0, 1'b0, 1'b0);
    check_eq("reset_x", int'(cursor_x), 320);
    check_eq("reset_y", int'(cursor_y), 240);

    // Basic motion: Y step is inverted.
    pkt(0, 10, 5);
    check_eq("move_x", int'(cursor_x), 320 + 10 * ACC);
    check_eq("move_y", int'(cursor_y), 235);

    // Clamp at zero, Y overflow ignored.
    pkt(0, -256, 255);
    pkt(0, -256, 255);
    pkt(0, 5, -5);
    do_cycle(1'b0, 1'b1, 0, -20, -256, 1'b0, 1'b1, 1'b0);
    check_eq("ovf_x", int'(cursor_x), 0);
    check_eq("ovf_y", int'(cursor_y), 5);

    // Clamp at max, no wrap.
    for (int i = 0; i < 3; i++) pkt(0, 255, -255);
    pkt(0, -5, 5);
    pkt(0, -4, 4);
    check_eq("pre_max_x", int'(cursor_x), 630);
    pkt(0, 50, -50);
    check_eq("max_x", int'(cursor_x), 639);
    check_eq("max_y", int'(cursor_y), 479);

    // Full selection and handshake.
    pkt(0, -200, 200);
    pkt(1, 0, 0);
    pkt(0, 100, -50);
    pkt(1, 0, 0);
    idle(1'b0);
    check_eq("sel_valid_hi", int'(sel_valid), 1);
    idle(1'b1);
    check_eq("sel_valid_lo", int'(sel_valid), 0);
    check_eq("state_idle", int'(sel_state), 0);

    // Left+right newly pressed in HAVE_START cancels.
    pkt(0, 0, 0);
    pkt(1, 3, 3);
    pkt(0, 0, 0);
    pkt(3, 7, -7);
    check_eq("cancel_state", int'(sel_state), 0);

    // Drop counting, ready with a left press in the same cycle.
    pkt(0, 0, 0);
    pkt(1, 0, 0);
    pkt(0, 0, 0);
    pkt(1, 0, 0);
    for (int i = 0; i < 3; i++) begin
      pkt(0, 1, 1);
      pkt(1, 1, 1);
    end
    pkt(0, 0, 0);
    do_cycle(1'b0, 1'b1, 1, 20, 0, 1'b0, 1'b0, 1'b1);
    check_eq("drop4", int'(drop_cnt), 4);
    check_eq("drop_state", int'(sel_state), 0);

    // Reset while PRESENT.
    pkt(0, 0, 0); pkt(1, 0, 0); pkt(0, 0, 0); pkt(1, 0, 0);
    do_cycle(1'b1, 1'b0, 0, 0, 0, 1'b0, 1'b0, 1'b0);
    check_eq("rst_present_valid", int'(sel_valid), 0);

    // Random traffic, biased toward left clicks so the FSM cycles.
    for (int i = 0; i < 4000; i++) begin
      bit rst, valid, xov, yov, ready;
      int btn, dx, dy;
      rst   = ($urandom_range(0, 299) == 0);
      valid = ($urandom_range(0, 9) < 6);
      btn   = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 7))
                                          : int'($urandom_range(0, 1));
      dx    = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 511)) - 256
                                          : int'($urandom_range(0, 40)) - 20;
      dy    = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 511)) - 256
                                          : int'($urandom_range(0, 40)) - 20;
      xov   = ($urandom_range(0, 15) == 0);
      yov   = ($urandom_range(0, 15) == 0);
      ready = ($urandom_range(0, 9) < 2);
      do_cycle(rst, valid, btn, dx, dy, xov, yov, ready);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
